// File: rtl/pipe_pkg.sv
// Shared sizing helpers and packed payload types for elastic pipeline chains.
package pipe_pkg;

  localparam int unsigned MAX_DEPTH = 8;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;

  // Occupancy counts up to DEPTH stages plus one skid entry.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      rs1_val;
    logic [XLEN-1:0]      rs2_val;
    logic [XLEN-1:0]      imm;
    logic [REG_IDX_W-1:0] rd;
  } id_ex_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry input skid buffer; lets in_ready come from a flop instead of the ready chain.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  input  logic             stage_ready,
  output logic             src_valid_c,
  output logic [WIDTH-1:0] src_data_c,
  output logic             skid_valid_nxt_c
);

  logic             skid_v;
  logic [WIDTH-1:0] skid_d;
  logic             park;

  assign in_ready    = ~skid_v;
  assign src_valid_c = skid_v | in_valid;
  assign src_data_c  = skid_v ? skid_d : in_data;

  // Park the accepted payload only when stage 0 cannot take it directly.
  assign park = in_valid & ~skid_v & ~stage_ready;

  always_comb begin
    skid_valid_nxt_c = skid_v;
    if (flush) begin
      skid_valid_nxt_c = 1'b0;
    end else if (skid_v && stage_ready) begin
      skid_valid_nxt_c = 1'b0;
    end else if (park) begin
      skid_valid_nxt_c = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      skid_v <= 1'b0;
      skid_d <= '0;
    end else begin
      skid_v <= skid_valid_nxt_c;
      if (park) begin
        skid_d <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_elastic_chain.sv
// Elastic DEPTH-stage payload register chain with valid/ready, bubble collapsing,
// per-stage flush and an optional registered-ready input skid buffer.
module pipe_elastic_chain
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 1,
  parameter bit          REG_READY = 1'b0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  input  logic [DEPTH-1:0]              flush,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int unsigned OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_nxt;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] ld;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];
  logic             src0_valid;
  logic [WIDTH-1:0] src0_data;
  logic             skid_v_nxt;
  logic [OCC_W-1:0] occ_nxt;

  if (REG_READY) begin : g_skid
    pipe_skid_buf #(.WIDTH(WIDTH)) u_skid (
      .clock            (clock),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_data          (in_data),
      .flush            (flush[0]),
      .stage_ready      (rdy[0]),
      .src_valid_c      (src0_valid),
      .src_data_c       (src0_data),
      .skid_valid_nxt_c (skid_v_nxt)
    );
  end else begin : g_direct
    assign in_ready   = rdy[0];
    assign src0_valid = in_valid;
    assign src0_data  = in_data;
    assign skid_v_nxt = 1'b0;
  end

  // A stage may load if it is empty or everything ahead of it moves.
  always_comb begin
    rdy[DEPTH-1] = out_ready | ~v[DEPTH-1];
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      rdy[i] = rdy[i+1] | ~v[i];
    end
  end

  always_comb begin
    src_v[0] = src0_valid;
    src_d[0] = src0_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  // Flush wins over both hold and load.
  always_comb begin
    v_nxt = v;
    ld    = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (rdy[i]) begin
        v_nxt[i] = src_v[i];
        ld[i]    = src_v[i];
      end
      if (flush[i]) begin
        v_nxt[i] = 1'b0;
        ld[i]    = 1'b0;
      end
    end
  end

  always_comb begin
    occ_nxt = OCC_W'(skid_v_nxt);
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_nxt = occ_nxt + OCC_W'(v_nxt[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v         <= '0;
      occupancy <= '0;
    end else begin
      v         <= v_nxt;
      occupancy <= occ_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (ld[i]) begin
          d[i] <= src_d[i];
        end
      end
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

endmodule
